// File: rtl/data_mem_responder.sv
// Word-addressed data-memory responder: valid/ready request and response channels around a RAM,
// one outstanding request, fixed access latency, byte-enable stores and error responses.
module data_mem_responder #(
  parameter int unsigned ADDR_BITS = 8,
  parameter int unsigned LATENCY   = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  input  logic [3:0]  req_be,
  output logic        resp_valid,
  input  logic        resp_ready,
  output logic [31:0] resp_rdata,
  output logic        resp_err
);

  if (LATENCY < 1 || LATENCY > 15) begin : gLatencyCheck
    $error("data_mem_responder: LATENCY must be in 1..15");
  end

  localparam int unsigned Depth = 2 ** ADDR_BITS;

  typedef enum logic [1:0] {
    StIdle,
    StBusy,
    StResp
  } state_e;

  state_e      stateQ, stateD;
  logic [3:0]  cntQ, cntD;
  logic        weQ, weD;
  logic [31:0] addrQ, addrD;
  logic [31:0] wdataQ, wdataD;
  logic [3:0]  beQ, beD;
  logic [31:0] rdataQ, rdataD;
  logic        errQ, errD;

  logic [31:0] mem [Depth];

  logic                 addrErr;
  logic [ADDR_BITS-1:0] wordIdx;
  logic                 accessFire;
  logic                 memWrite;

  assign wordIdx    = addrQ[ADDR_BITS+1:2];
  assign addrErr    = (addrQ[1:0] != 2'b00) | (|addrQ[31:ADDR_BITS+2]);
  assign accessFire = (stateQ == StBusy) && (cntQ == 4'd0);
  assign memWrite   = accessFire && weQ && !addrErr;

  assign req_ready  = (stateQ == StIdle);
  assign resp_valid = (stateQ == StResp);
  assign resp_rdata = rdataQ;
  assign resp_err   = errQ;

  always_comb begin
    stateD = stateQ;
    cntD   = cntQ;
    weD    = weQ;
    addrD  = addrQ;
    wdataD = wdataQ;
    beD    = beQ;
    rdataD = rdataQ;
    errD   = errQ;

    unique case (stateQ)
      StIdle: begin
        if (req_valid) begin
          weD    = req_we;
          addrD  = req_addr;
          wdataD = req_wdata;
          beD    = req_be;
          cntD   = 4'(LATENCY - 1);
          stateD = StBusy;
        end
      end
      StBusy: begin
        if (cntQ == 4'd0) begin
          // Errors and stores both return zero data; only clean loads read the array.
          rdataD = (weQ || addrErr) ? 32'h0 : mem[wordIdx];
          errD   = addrErr;
          stateD = StResp;
        end else begin
          cntD = cntQ - 4'd1;
        end
      end
      StResp: begin
        if (resp_ready) begin
          rdataD = 32'h0;
          errD   = 1'b0;
          stateD = StIdle;
        end
      end
      default: stateD = StIdle;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stateQ <= StIdle;
      cntQ   <= 4'd0;
      weQ    <= 1'b0;
      addrQ  <= 32'h0;
      wdataQ <= 32'h0;
      beQ    <= 4'h0;
      rdataQ <= 32'h0;
      errQ   <= 1'b0;
    end else begin
      stateQ <= stateD;
      cntQ   <= cntD;
      weQ    <= weD;
      addrQ  <= addrD;
      wdataQ <= wdataD;
      beQ    <= beD;
      rdataQ <= rdataD;
      errQ   <= errD;
    end
  end

  // Storage is deliberately not reset.
  always_ff @(posedge clk) begin
    if (memWrite) begin
      for (int lane = 0; lane < 4; lane++) begin
        if (beQ[lane]) begin
          mem[wordIdx][lane*8 +: 8] <= wdataQ[lane*8 +: 8];
        end
      end
    end
  end

endmodule

// File: tb/tb_data_mem_responder.sv
// Directed bench for data_mem_responder: table of load/store vectors plus hand-written
// backpressure and reset corner sequences.
module tb_data_mem_responder;

  localparam int unsigned AddrBits = 8;
  localparam int unsigned Lat      = 2;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic        req_we = 1'b0;
  logic [31:0] req_addr = 32'h0;
  logic [31:0] req_wdata = 32'h0;
  logic [3:0]  req_be = 4'h0;
  logic        resp_valid;
  logic        resp_ready = 1'b0;
  logic [31:0] resp_rdata;
  logic        resp_err;

  int testsRun = 0;
  int testsFailed = 0;

  data_mem_responder #(
    .ADDR_BITS(AddrBits),
    .LATENCY  (Lat)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_we    (req_we),
    .req_addr  (req_addr),
    .req_wdata (req_wdata),
    .req_be    (req_be),
    .resp_valid(resp_valid),
    .resp_ready(resp_ready),
    .resp_rdata(resp_rdata),
    .resp_err  (resp_err)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  be;
    logic [31:0] expRdata;
    logic        expErr;
  } vec_t;

  localparam int NumVecs = 17;
  vec_t vecs [NumVecs];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    testsRun++;
    if (act !== exp) begin
      testsFailed++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endtask

  // Wait on negedges for resp_valid; returns the number of negedges waited (0 on timeout).
  task automatic waitResp(output int k);
    k = 0;
    for (int i = 1; i <= 40; i++) begin
      @(negedge clk);
      if (resp_valid === 1'b1) begin
        k = i;
        break;
      end
    end
  endtask

  task automatic doTxn(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                       input logic [3:0] be, input string tag,
                       output logic [31:0] rdata, output logic err);
    int k;
    @(negedge clk);
    check({tag, ".ready_in"}, 32'(req_ready), 32'd1);
    req_we     = we;
    req_addr   = addr;
    req_wdata  = wdata;
    req_be     = be;
    req_valid  = 1'b1;
    resp_ready = 1'b1;
    @(posedge clk);
    #1 req_valid = 1'b0;
    waitResp(k);
    check({tag, ".latency"}, 32'(k), 32'(Lat + 1));
    rdata = resp_rdata;
    err   = resp_err;
    @(negedge clk);
    check({tag, ".post_valid_ready"}, {30'h0, resp_valid, req_ready}, 32'b01);
  endtask

  initial begin
    logic [31:0] rd;
    logic        er;
    int          k;

    //            we    addr          wdata         be       expRdata      expErr
    vecs[0]  = '{1'b1, 32'h0000_0010, 32'hDEAD_BEEF, 4'hF, 32'h0000_0000, 1'b0};
    vecs[1]  = '{1'b0, 32'h0000_0010, 32'h0,         4'h0, 32'hDEAD_BEEF, 1'b0};
    vecs[2]  = '{1'b1, 32'h0000_0010, 32'h1122_3344, 4'h5, 32'h0000_0000, 1'b0};
    vecs[3]  = '{1'b0, 32'h0000_0010, 32'h0,         4'hF, 32'hDE22_BE44, 1'b0};
    vecs[4]  = '{1'b0, 32'h0000_0013, 32'h0,         4'hF, 32'h0000_0000, 1'b1};
    vecs[5]  = '{1'b1, 32'h0000_0000, 32'hA5A5_A5A5, 4'hF, 32'h0000_0000, 1'b0};
    vecs[6]  = '{1'b1, 32'h0000_0400, 32'hFFFF_FFFF, 4'hF, 32'h0000_0000, 1'b1};
    vecs[7]  = '{1'b0, 32'h0000_0000, 32'h0,         4'h0, 32'hA5A5_A5A5, 1'b0};
    vecs[8]  = '{1'b1, 32'h0000_0000, 32'h7700_0000, 4'h8, 32'h0000_0000, 1'b0};
    vecs[9]  = '{1'b0, 32'h0000_0000, 32'h0,         4'h0, 32'h77A5_A5A5, 1'b0};
    vecs[10] = '{1'b1, 32'h0000_0004, 32'hCAFE_0001, 4'hF, 32'h0000_0000, 1'b0};
    vecs[11] = '{1'b1, 32'h0000_0004, 32'hFFFF_FFFF, 4'h0, 32'h0000_0000, 1'b0};
    vecs[12] = '{1'b0, 32'h0000_0004, 32'h0,         4'h0, 32'hCAFE_0001, 1'b0};
    vecs[13] = '{1'b1, 32'h0000_03FC, 32'h0BAD_F00D, 4'hF, 32'h0000_0000, 1'b0};
    vecs[14] = '{1'b0, 32'h0000_03FC, 32'h0,         4'h0, 32'h0BAD_F00D, 1'b0};
    vecs[15] = '{1'b0, 32'h8000_0000, 32'h0,         4'h0, 32'h0000_0000, 1'b1};
    vecs[16] = '{1'b1, 32'h0000_0020, 32'h0000_0000, 4'hF, 32'h0000_0000, 1'b0};

    // Asynchronous reset asserted mid-cycle.
    #3 rst = 1'b1;
    #1;
    check("rst.req_ready",  32'(req_ready),  32'd1);
    check("rst.resp_valid", 32'(resp_valid), 32'd0);
    check("rst.resp_rdata", resp_rdata,      32'h0);
    check("rst.resp_err",   32'(resp_err),   32'd0);
    @(negedge clk);
    rst = 1'b0;
    #1;
    check("rel.outputs", {29'h0, req_ready, resp_valid, resp_err}, 32'b100);
    check("rel.resp_rdata", resp_rdata, 32'h0);

    for (int i = 0; i < NumVecs; i++) begin
      doTxn(vecs[i].we, vecs[i].addr, vecs[i].wdata, vecs[i].be, $sformatf("v%0d", i), rd, er);
      check($sformatf("v%0d.rdata", i), rd, vecs[i].expRdata);
      check($sformatf("v%0d.err", i), 32'(er), 32'(vecs[i].expErr));
    end

    // Backpressure: hold the response, with the next request already waiting.
    @(negedge clk);
    resp_ready = 1'b0;
    req_we = 1'b0; req_addr = 32'h10; req_be = 4'h0; req_valid = 1'b1;
    @(posedge clk);
    #1 req_addr = 32'h0;
    waitResp(k);
    check("bp.latency", 32'(k), 32'(Lat + 1));
    for (int i = 0; i < 5; i++) begin
      check($sformatf("bp.hold%0d.valid_ready", i), {30'h0, resp_valid, req_ready}, 32'b10);
      check($sformatf("bp.hold%0d.rdata", i), resp_rdata, 32'hDE22_BE44);
      check($sformatf("bp.hold%0d.err", i), 32'(resp_err), 32'd0);
      @(negedge clk);
    end
    resp_ready = 1'b1;
    @(posedge clk);
    #1 resp_ready = 1'b0;
    @(negedge clk);
    check("bp.turn.valid_ready", {30'h0, resp_valid, req_ready}, 32'b01);
    @(posedge clk);
    #1;
    check("bp.accepted.ready", 32'(req_ready), 32'd0);
    req_valid = 1'b0;
    waitResp(k);
    check("bp2.latency", 32'(k), 32'(Lat + 1));
    check("bp2.rdata", resp_rdata, 32'h77A5_A5A5);
    check("bp2.err", 32'(resp_err), 32'd0);
    resp_ready = 1'b1;
    @(negedge clk);
    check("bp2.post_valid_ready", {30'h0, resp_valid, req_ready}, 32'b01);

    // Reset during BUSY aborts the store.
    req_we = 1'b1; req_addr = 32'h20; req_wdata = 32'hCAFE_F00D; req_be = 4'hF; req_valid = 1'b1;
    @(posedge clk);
    #1 req_valid = 1'b0;
    @(negedge clk);
    check("abort.busy_ready", 32'(req_ready), 32'd0);
    rst = 1'b1;
    #1;
    check("abort.rst_valid_ready", {30'h0, resp_valid, req_ready}, 32'b01);
    @(negedge clk);
    rst = 1'b0;
    doTxn(1'b0, 32'h20, 32'h0, 4'h0, "abort.load", rd, er);
    check("abort.load.rdata", rd, 32'h0);
    check("abort.load.err", 32'(er), 32'd0);

    // Reset during RESP discards the response but keeps the completed store.
    @(negedge clk);
    resp_ready = 1'b0;
    req_we = 1'b1; req_addr = 32'h24; req_wdata = 32'h1357_9BDF; req_be = 4'hF; req_valid = 1'b1;
    @(posedge clk);
    #1 req_valid = 1'b0;
    waitResp(k);
    check("rresp.latency", 32'(k), 32'(Lat + 1));
    #2 rst = 1'b1;
    #1;
    check("rresp.rst_valid_ready", {30'h0, resp_valid, req_ready}, 32'b01);
    check("rresp.rst_rdata_err", {resp_rdata[30:0], resp_err}, 32'h0);
    @(negedge clk);
    rst = 1'b0;
    doTxn(1'b0, 32'h24, 32'h0, 4'h0, "rresp.load", rd, er);
    check("rresp.load.rdata", rd, 32'h1357_9BDF);
    check("rresp.load.err", 32'(er), 32'd0);

    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule

// File: doc/data_mem_responder.md
Name: data_mem_responder

Overview:
- Word-addressed data-memory responder: the target end of the processor's load/store interface (address, write data and write enable in; read data out).
- Wraps an internal RAM behind a valid/ready request channel and a valid/ready response channel with a fixed, parameterised access latency.
- Sits between the datapath's memory port (or its stall/handshake adapter) and storage; enables multi-cycle memory timing for later core variants.
- Supports one outstanding request, byte-enable writes, and error responses for misaligned or out-of-range addresses.

Parameters:
ADDR_BITS, 8, log2 of RAM depth in 32-bit words (256 words).
LATENCY, 2, cycles from request acceptance to response valid; legal range 1..15; 0 is illegal.

Ports:
clk  input  1  single clock; all state changes on rising edge.
rst  input  1  reset, asynchronous, active-high.
req_valid  input  1  request present.
req_ready  output  1  responder can accept a request this cycle.
req_we  input  1  1 = store, 0 = load.
req_addr  input  32  byte address.
req_wdata  input  32  store data.
req_be  input  4  byte enables for stores; be[0] selects bits 7:0, be[3] selects bits 31:24.
resp_valid  output  1  response present.
resp_ready  input  1  requester accepts the response.
resp_rdata  output  32  load data; 0 for stores and errors.
resp_err  output  1  request was misaligned or out of range.

Behaviour:
- Reset (async, rst=1):
  - state=IDLE, req_ready=1, resp_valid=0, resp_rdata=0, resp_err=0, latency counter=0.
  - Captured request registers cleared.
  - RAM contents are not reset.
- FSM states: IDLE, BUSY, RESP.
- IDLE:
  - req_ready=1.
  - On an edge with req_valid&&req_ready: capture addr, we, wdata and be; counter<=LATENCY-1; go to BUSY.
- BUSY:
  - req_ready=0.
  - Counter decrements each edge.
  - At the edge where counter==0, perform the access and go to RESP.
  - Result: request accepted at edge N gives resp_valid=1 after edge N+LATENCY.
- Access rules:
  - Word index = addr[ADDR_BITS+1:2].
  - err = (addr[1:0]!=0) | (addr[31:ADDR_BITS+2]!=0).
  - On err: no RAM read or write; resp_err=1, resp_rdata=0.
  - Load: resp_rdata = full RAM word; be ignored.
  - Store: write only the enabled byte lanes; resp_rdata=0; resp_err=0.
  - Store with be=4'b0000: no RAM change, normal ack.
- RESP:
  - resp_valid, resp_rdata and resp_err stay stable until resp_ready=1.
  - On an edge with resp_valid&&resp_ready: go to IDLE; resp_valid, resp_rdata and resp_err clear to 0.
  - req_ready rises in the cycle after the handshake; there is no same-cycle turnaround.
  - Minimum request-to-request spacing is LATENCY+2 cycles.
- Input stability:
  - req_* inputs are ignored outside the accept edge.
  - req_valid high while req_ready=0 is legal; the request waits and is not dropped.
- Read-after-write: a load following a store to the same word returns the updated data.
- Reset mid-operation:
  - Reset in BUSY before the access edge aborts the request; no RAM write occurs.
  - Reset in RESP discards the response; a store already performed remains in RAM.
- resp_ready high while in IDLE or BUSY has no effect.

Test Plan:
- Reset check: assert rst mid-cycle (asynchronously), release -> req_ready=1, resp_valid=0, resp_rdata=0, resp_err=0 immediately.
- Store then load, LATENCY=2, resp_ready held at 1:
  - Store addr=0x10, wdata=0xDEADBEEF, be=4'hF, accepted at edge N -> resp_valid high after edge N+2 with rdata=0, err=0; req_ready=1 one cycle after the handshake.
  - Load addr=0x10 -> rdata=0xDEADBEEF.
- Byte enables: store 0x11223344 with be=4'b0101 over word 0xDEADBEEF at 0x10 -> subsequent load returns 0xDE22BE44.
- Errors:
  - Load addr=0x13 (misaligned) -> resp_err=1, rdata=0.
  - Store addr=0x400 (ADDR_BITS=8, out of range) -> resp_err=1, and a load of word 0 is unchanged.
- Backpressure: hold resp_ready=0 for 5 cycles after resp_valid -> rdata, err and valid stay stable and req_ready=0; drop resp_ready to 0 again after the handshake -> next request accepted exactly one cycle later.
- Reset abort: assert rst during BUSY of a store of 0xCAFEF00D to 0x20 (previously 0x0) -> after reset, a load of 0x20 returns 0x0.
